// File: rtl/axi_sram_slave_pkg.sv
// Shared types for the single-beat AXI3 SRAM slave:
// response code and the read/write FSM state encodings.
package axi_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_e;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 ar/r/aw/w/b channel bundle between the sram bridge
// and the SRAM slave.
interface axi_sram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_slave_rq_fifo.sv
// Read-address queue: small synchronous FIFO of {id, index}
// with first-word-fall-through head.
module axi_slave_rq_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(do_push);
            rd_q  <= rd_q + PW'(do_pop);
            cnt_q <= cnt_q + (PW+1)'(do_push)
                           - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave over a byte-writable word RAM with
// an in-order read queue and independent read/write FSMs.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int RD_LAT   = 2,
    parameter int RQ_DEPTH = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_sram_slave_if.slave   s
);

    localparam int QW    = 4 + ADDR_W;
    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    logic [31:0] ram_q [2**ADDR_W];

    // Holds the ready outputs low through reset and until the first edge.
    logic live_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) live_q <= 1'b0;
        else          live_q <= 1'b1;
    end

    logic unused_ok;
    assign unused_ok = ^{s.araddr[31:ADDR_W+2], s.araddr[1:0],
                         s.awaddr[31:ADDR_W+2], s.awaddr[1:0],
                         s.arlen, s.arsize};

    // ---------------- read path ----------------
    logic          rq_full, rq_empty, rq_pop, ar_push;
    logic [QW-1:0] rq_head;

    assign s.arready = live_q && !rq_full;
    assign ar_push   = s.arvalid && s.arready;

    axi_slave_rq_fifo #(
        .DEPTH (RQ_DEPTH),
        .W     (QW)
    ) u_rq (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push_i  (ar_push),
        .data_i  ({s.arid, s.araddr[ADDR_W+1:2]}),
        .pop_i   (rq_pop),
        .full_o  (rq_full),
        .empty_o (rq_empty),
        .head_o  (rq_head)
    );

    r_state_e          r_state_q, r_state_d;
    logic [3:0]        rid_q, rid_d;
    logic [ADDR_W-1:0] ridx_q, ridx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            ridx_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (!rq_empty)      r_state_d = R_WAIT;
            R_WAIT: if (cnt_q == '0)    r_state_d = R_RESP;
            R_RESP: if (s.rready)       r_state_d = R_IDLE;
            default:                    r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rq_pop  = 1'b0;
        rid_d   = rid_q;
        ridx_d  = ridx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (!rq_empty) begin
                    rq_pop = 1'b1;
                    rid_d  = rq_head[QW-1 -: 4];
                    ridx_d = rq_head[ADDR_W-1:0];
                    cnt_d  = CNT_W'(RD_LAT);
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) rdata_d = ram_q[ridx_q];
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign s.rvalid = r_state_q == R_RESP;
    assign s.rid    = rid_q;
    assign s.rdata  = rdata_q;
    assign s.rresp  = RESP_OKAY;
    assign s.rlast  = 1'b1;

    // ---------------- write path ----------------
    w_state_e          w_state_q, w_state_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [3:0]        awid_q, awid_d, bid_q, bid_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_hs, w_hs, both, commit;

    assign s.awready = live_q && w_state_q == W_COLLECT && !aw_got_q;
    assign s.wready  = live_q && w_state_q == W_COLLECT && !w_got_q;
    assign aw_hs     = s.awvalid && s.awready;
    assign w_hs      = s.wvalid && s.wready;
    assign both      = (aw_got_q || aw_hs) && (w_got_q || w_hs);
    assign commit    = w_state_q == W_COLLECT && both;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_COLLECT;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awid_q    <= '0;
            bid_q     <= '0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awid_q    <= awid_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_COLLECT: if (both)      w_state_d = W_RESP;
            W_RESP:    if (s.bready)  w_state_d = W_COLLECT;
            default:                  w_state_d = W_COLLECT;
        endcase
    end

    // Channel captures; a same-edge handshake bypasses the holding regs.
    always_comb begin
        awid_d   = aw_hs ? s.awid : awid_q;
        widx_d   = aw_hs ? s.awaddr[ADDR_W+1:2] : widx_q;
        wdata_d  = w_hs ? s.wdata : wdata_q;
        wstrb_d  = w_hs ? s.wstrb : wstrb_q;
        aw_got_d = commit ? 1'b0 : (aw_got_q || aw_hs);
        w_got_d  = commit ? 1'b0 : (w_got_q || w_hs);
        bid_d    = commit ? awid_d : bid_q;
    end

    always_ff @(posedge aclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_d[b])
                    ram_q[widx_d][8*b +: 8] <= wdata_d[8*b +: 8];
            end
        end
    end

    assign s.bvalid = w_state_q == W_RESP;
    assign s.bid    = bid_q;
    assign s.bresp  = RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read ordering,
// byte strobes, queue full, backpressure, wrap and reset.
module tb_axi_sram_slave;

    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;
    localparam int AR2R   = RD_LAT + 2;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .RQ_DEPTH (2)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s       (bus)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ar_push(input logic [31:0] a,
                           input logic [3:0] id);
        int n;
        n = 0;
        bus.arvalid = 1'b1;
        bus.araddr  = a;
        bus.arid    = id;
        while (!bus.arready && n < 50) begin
            tick();
            n++;
        end
        chk("ar_timeout", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic r_collect(input logic [3:0] id,
                             input logic [31:0] d,
                             output int lat);
        lat = 0;
        while (!bus.rvalid && lat < 50) begin
            tick();
            lat++;
        end
        chk("r_valid", 32'(bus.rvalid), 32'd1);
        chk("r_id", 32'(bus.rid), 32'(id));
        chk("r_data", bus.rdata, d);
        chk("r_last", 32'(bus.rlast), 32'd1);
        chk("r_resp", 32'(bus.rresp), 32'd0);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("r_drop", 32'(bus.rvalid), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a,
                      input logic [3:0] id,
                      input logic [31:0] d);
        int lat;
        ar_push(a, id);
        r_collect(id, d, lat);
        chk("r_lat", 32'(lat), 32'(AR2R));
    endtask

    task automatic b_take(input logic [3:0] id);
        chk("b_valid", 32'(bus.bvalid), 32'd1);
        chk("b_id", 32'(bus.bid), 32'(id));
        chk("b_resp", 32'(bus.bresp), 32'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("b_drop", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic aw_w(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] st,
                        input logic [3:0] id);
        int  n;
        logic ga, gw;
        n = 0;
        bus.awvalid = 1'b1;
        bus.awaddr  = a;
        bus.awid    = id;
        bus.wvalid  = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = st;
        while ((bus.awvalid || bus.wvalid) && n < 50) begin
            ga = bus.awvalid && bus.awready;
            gw = bus.wvalid && bus.wready;
            tick();
            if (ga) bus.awvalid = 1'b0;
            if (gw) bus.wvalid = 1'b0;
            n++;
        end
        chk("w_timeout", 32'(n < 50), 32'd1);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] st,
                      input logic [3:0] id);
        aw_w(a, d, st, id);
        b_take(id);
    endtask

    initial begin
        int  lat;
        logic stale;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0;
        bus.arlen = 0; bus.arsize = 3'd2; bus.rready = 0;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0;

        repeat (3) tick();
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd1);
        aresetn = 1'b1;
        chk("rel_arready_lo", 32'(bus.arready), 32'd0);
        tick();
        chk("rel_arready", 32'(bus.arready), 32'd1);
        chk("rel_awready", 32'(bus.awready), 32'd1);
        chk("rel_wready", 32'(bus.wready), 32'd1);

        // simultaneous aw/w, then read back
        wr(32'h100, 32'hDEADBEEF, 4'hF, 4'd1);
        rd(32'h100, 4'd0, 32'hDEADBEEF);

        // w three cycles before aw, partial strobes over zero
        wr(32'h104, 32'h0, 4'hF, 4'd2);
        bus.wvalid = 1'b1;
        bus.wdata  = 32'h11223344;
        bus.wstrb  = 4'b0101;
        chk("w_first_ready", 32'(bus.wready), 32'd1);
        tick();
        bus.wvalid = 1'b0;
        chk("w_only_wready", 32'(bus.wready), 32'd0);
        repeat (3) tick();
        chk("w_only_bvalid", 32'(bus.bvalid), 32'd0);
        bus.awvalid = 1'b1;
        bus.awaddr  = 32'h104;
        bus.awid    = 4'd3;
        chk("aw_late_ready", 32'(bus.awready), 32'd1);
        tick();
        bus.awvalid = 1'b0;
        b_take(4'd3);
        rd(32'h104, 4'd1, 32'h00220044);

        // zero strobes still respond, data unchanged
        wr(32'h104, 32'hFFFFFFFF, 4'h0, 4'd4);
        rd(32'h104, 4'd2, 32'h00220044);

        // address wrap modulo depth
        wr(32'h4008, 32'hCAFEF00D, 4'hF, 4'd5);
        rd(32'h8, 4'd3, 32'hCAFEF00D);
        wr(32'h0, 32'h0BADF00D, 4'hF, 4'd6);
        wr(32'h4, 32'h12345678, 4'hF, 4'd7);

        // fill the queue while the first response is stalled
        bus.arvalid = 1'b1;
        bus.arid = 4'd4; bus.araddr = 32'h0;
        chk("q_rdy0", 32'(bus.arready), 32'd1);
        tick();
        bus.arid = 4'd5; bus.araddr = 32'h4;
        chk("q_rdy1", 32'(bus.arready), 32'd1);
        tick();
        bus.arid = 4'd6; bus.araddr = 32'h8;
        chk("q_rdy2", 32'(bus.arready), 32'd1);
        tick();
        bus.arid = 4'd7; bus.araddr = 32'hC;
        chk("q_full", 32'(bus.arready), 32'd0);
        tick();
        chk("q_full_hold", 32'(bus.arready), 32'd0);
        bus.arvalid = 1'b0;
        r_collect(4'd4, 32'h0BADF00D, lat);
        r_collect(4'd5, 32'h12345678, lat);
        r_collect(4'd6, 32'hCAFEF00D, lat);
        stale = 1'b0;
        repeat (8) begin
            tick();
            stale = stale | bus.rvalid;
        end
        chk("q_no_extra", 32'(stale), 32'd0);

        // rready backpressure with a second read queued
        ar_push(32'h100, 4'd8);
        ar_push(32'h104, 4'd9);
        lat = 0;
        while (!bus.rvalid && lat < 50) begin
            tick();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.rvalid), 32'd1);
            chk("bp_id", 32'(bus.rid), 32'd8);
            chk("bp_data", bus.rdata, 32'hDEADBEEF);
        end
        r_collect(4'd8, 32'hDEADBEEF, lat);
        r_collect(4'd9, 32'h00220044, lat);
        chk("bp_next_lat", 32'(lat), 32'(AR2R));

        // reset mid R_WAIT with bvalid pending and queue loaded
        aw_w(32'h8, 32'h55555555, 4'hF, 4'd6);
        chk("wresp_bvalid", 32'(bus.bvalid), 32'd1);
        chk("wresp_awready", 32'(bus.awready), 32'd0);
        ar_push(32'h0, 4'd10);
        ar_push(32'h4, 4'd11);
        tick();
        #2;
        aresetn = 1'b0;
        #1;
        chk("ar_rvalid", 32'(bus.rvalid), 32'd0);
        chk("ar_bvalid", 32'(bus.bvalid), 32'd0);
        chk("ar_arready", 32'(bus.arready), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("post_arready", 32'(bus.arready), 32'd1);
        stale = 1'b0;
        repeat (10) begin
            tick();
            stale = stale | bus.rvalid | bus.bvalid;
        end
        chk("post_no_stale", 32'(stale), 32'd0);
        rd(32'h8, 4'd12, 32'h55555555);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
